// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan stage: active-low segment codes,
// digit slot indices and adjust-selector codes.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam int DP_BIT = 7;

   localparam logic [5:0] SEL_NONE = 6'h3F;

   localparam logic [2:0] IDX_SEC_L  = 3'd0;
   localparam logic [2:0] IDX_SEC_H  = 3'd1;
   localparam logic [2:0] IDX_MIN_L  = 3'd2;
   localparam logic [2:0] IDX_MIN_H  = 3'd3;
   localparam logic [2:0] IDX_HOUR_L = 3'd4;
   localparam logic [2:0] IDX_HOUR_H = 3'd5;

   typedef enum logic [1:0] {
      ADJ_RUN  = 2'd0,
      ADJ_SEC  = 2'd1,
      ADJ_MIN  = 2'd2,
      ADJ_HOUR = 2'd3
   } adj_e;

   // Anything outside 0..9 is shown as a dash so corrupt counter state is visible.
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
      logic [7:0] code;
      case (bcd)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_DASH;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational digit encoder: BCD value plus blank/dp flags to an
// active-low segment pattern.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      // NOTE: seg gets a full default before any conditional override, so no latch is inferred.
      seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
      if (dp) begin
         seg[DP_BIT] = 1'b0;
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Six-digit common-anode display scanner with anti-ghost dead time and
// blinking of the digit pair under adjustment.
module seg_scan
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DEAD_CYC  = 500,
   parameter int BLINK_DIV = 12500000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_hour_h,
   input  logic [3:0] i_hour_l,
   input  logic [3:0] i_minut_h,
   input  logic [3:0] i_minut_l,
   input  logic [3:0] i_second_h,
   input  logic [3:0] i_second_l,
   input  logic [1:0] i_adjust_cnt,
   output logic [7:0] o_seg,
   output logic [5:0] o_sel
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] DEAD_END   = SW'(DEAD_CYC);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] slot_cnt;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_hidden;

   logic          slot_end;
   logic          blink_end;
   logic          dead;
   logic [3:0]    digit;
   logic          in_adj_pair;
   logic          blank;
   logic          dp;
   logic [7:0]    dec_seg;
   logic [7:0]    seg_next;
   logic [5:0]    sel_next;

   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign blink_end = (blink_cnt == BLINK_LAST);
   assign dead      = (slot_cnt < DEAD_END);

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_reset) begin
         slot_cnt     <= '0;
         idx          <= IDX_SEC_L;
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else begin
         slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
         if (slot_end) begin
            idx <= (idx == IDX_HOUR_H) ? IDX_SEC_L : idx + 3'd1;
         end
         // Blink timing free-runs; adjust changes only move which pair is blanked.
         blink_cnt <= blink_end ? '0 : blink_cnt + BW'(1);
         if (blink_end) begin
            blink_hidden <= ~blink_hidden;
         end
      end
   end

   always_comb begin
      digit = i_second_l;
      case (idx)
         IDX_SEC_L:  digit = i_second_l;
         IDX_SEC_H:  digit = i_second_h;
         IDX_MIN_L:  digit = i_minut_l;
         IDX_MIN_H:  digit = i_minut_h;
         IDX_HOUR_L: digit = i_hour_l;
         IDX_HOUR_H: digit = i_hour_h;
         default:    digit = i_second_l;
      endcase
   end

   always_comb begin
      in_adj_pair = 1'b0;
      case (adj_e'(i_adjust_cnt))
         ADJ_SEC:  in_adj_pair = (idx == IDX_SEC_L)  || (idx == IDX_SEC_H);
         ADJ_MIN:  in_adj_pair = (idx == IDX_MIN_L)  || (idx == IDX_MIN_H);
         ADJ_HOUR: in_adj_pair = (idx == IDX_HOUR_L) || (idx == IDX_HOUR_H);
         default:  in_adj_pair = 1'b0;
      endcase
   end

   assign blank = blink_hidden && in_adj_pair;
   // Separator dots after hours and minutes stay lit even while the digit blinks.
   assign dp    = (idx == IDX_MIN_L) || (idx == IDX_HOUR_L);

   seg_decode u_decode (
      .bcd   (digit),
      .blank (blank),
      .dp    (dp),
      .seg   (dec_seg)
   );

   assign sel_next = dead ? SEL_NONE : ~(6'b000001 << idx);
   assign seg_next = dead ? SEG_BLANK : dec_seg;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_seg <= SEG_BLANK;
         o_sel <= SEL_NONE;
      end else begin
         o_seg <= seg_next;
         o_sel <= sel_next;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: an arithmetic reference model predicts each
// registered output cycle, expectations are queued and compared after the edge.
module tb_seg_scan;

   localparam int SCAN_DIV  = 4;
   localparam int DEAD_CYC  = 1;
   localparam int BLINK_DIV = 10;

   typedef struct packed {
      logic [5:0] sel;
      logic [7:0] seg;
   } out_t;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [3:0] i_hour_h, i_hour_l, i_minut_h, i_minut_l, i_second_h, i_second_l;
   logic [1:0] i_adjust_cnt;
   logic [7:0] o_seg;
   logic [5:0] o_sel;

   int   checks   = 0;
   int   failures = 0;
   int   cnt      = 0;
   int   dp_only_seen = 0;
   out_t sb_q[$];

   logic [7:0] code_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   seg_scan #(
      .SCAN_DIV  (SCAN_DIV),
      .DEAD_CYC  (DEAD_CYC),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_hour_h     (i_hour_h),
      .i_hour_l     (i_hour_l),
      .i_minut_h    (i_minut_h),
      .i_minut_l    (i_minut_l),
      .i_second_h   (i_second_h),
      .i_second_l   (i_second_l),
      .i_adjust_cnt (i_adjust_cnt),
      .o_seg        (o_seg),
      .o_sel        (o_sel)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Outputs produced by the edge that follows state count c (non-reset edges since reset).
   function automatic out_t model(input int c);
      out_t       r;
      int         slot = c % SCAN_DIV;
      int         ix   = (c / SCAN_DIV) % 6;
      bit         hid  = ((c / BLINK_DIV) % 2) == 1;
      logic [3:0] d;
      bit         blank;
      case (ix)
         0:       d = i_second_l;
         1:       d = i_second_h;
         2:       d = i_minut_l;
         3:       d = i_minut_h;
         4:       d = i_hour_l;
         default: d = i_hour_h;
      endcase
      blank = hid && ((i_adjust_cnt == 2'd1 && ix <= 1) ||
                      (i_adjust_cnt == 2'd2 && (ix == 2 || ix == 3)) ||
                      (i_adjust_cnt == 2'd3 && ix >= 4));
      if (slot < DEAD_CYC) begin
         r.sel = 6'h3F;
         r.seg = 8'hFF;
      end else begin
         r.sel = 6'h3F;
         r.sel[ix] = 1'b0;
         if (blank)      r.seg = 8'hFF;
         else if (d > 9) r.seg = 8'hBF;
         else            r.seg = code_tbl[d];
         if (ix == 2 || ix == 4) r.seg[7] = 1'b0;
      end
      return r;
   endfunction

   task automatic step();
      out_t e;
      out_t a;
      if (i_reset) begin
         e.sel = 6'h3F;
         e.seg = 8'hFF;
      end else begin
         e = model(cnt);
      end
      sb_q.push_back(e);
      @(posedge i_clk);
      #1;
      if (i_reset) cnt = 0;
      else         cnt++;
      a = sb_q.pop_front();
      check("sb_sel", 32'(o_sel), 32'(a.sel));
      check("sb_seg", 32'(o_seg), 32'(a.seg));
      check("sel_single", 32'($countones(~o_sel) <= 1), 32'd1);
      if (o_seg == 8'h7F) dp_only_seen++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the state count sits at (ix, slot), then one more edge to show it.
   task automatic run_to(input int ix, input int sl);
      int guard = 0;
      while (!(((cnt / SCAN_DIV) % 6) == ix && (cnt % SCAN_DIV) == sl) && guard < 3 * SCAN_DIV * 6) begin
         step();
         guard++;
      end
      check("run_to_bound", 32'(guard < 3 * SCAN_DIV * 6), 32'd1);
      step();
   endtask

   task automatic set_time(input logic [3:0] hh, hl, mh, ml, sh, sl);
      i_hour_h = hh; i_hour_l = hl; i_minut_h = mh;
      i_minut_l = ml; i_second_h = sh; i_second_l = sl;
   endtask

   initial begin
      i_reset = 1'b1;
      i_adjust_cnt = 2'd0;
      set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      step();
      check("reset_sel", 32'(o_sel), 32'h3F);
      check("reset_seg", 32'(o_seg), 32'hFF);
      i_reset = 1'b0;

      // Directed scan sequence at 12:34:56.
      run(2);
      check("idx0_sel", 32'(o_sel), 32'h3E);
      check("idx0_seg", 32'(o_seg), 32'h82);
      run(3);
      check("slot1_dead_sel", 32'(o_sel), 32'h3F);
      run(1);
      check("idx1_sel", 32'(o_sel), 32'h3D);
      check("idx1_seg", 32'(o_seg), 32'h92);
      run(4);
      check("idx2_sel", 32'(o_sel), 32'h3B);
      check("idx2_seg_dp", 32'(o_seg), 32'h19);
      run(12);
      check("idx5_sel", 32'(o_sel), 32'h1F);
      check("idx5_seg", 32'(o_seg), 32'hF9);
      run(4);
      check("wrap_idx0_sel", 32'(o_sel), 32'h3E);
      run(24);

      // Minute pair blinking.
      i_adjust_cnt = 2'd2;
      run(72);
      check("blink_dp_only_seen", 32'(dp_only_seen > 0), 32'd1);

      // Invalid BCD on hour tens, then restored.
      i_adjust_cnt = 2'd0;
      i_hour_h = 4'hC;
      run_to(5, 1);
      check("dash_seg", 32'(o_seg), 32'hBF);
      i_hour_h = 4'd2;
      run_to(5, 1);
      check("restored_seg", 32'(o_seg), 32'hA4);

      // Reset mid-slot at index 3.
      i_adjust_cnt = 2'd2;
      run_to(3, 2);
      i_reset = 1'b1;
      step();
      check("midreset_sel", 32'(o_sel), 32'h3F);
      check("midreset_seg", 32'(o_seg), 32'hFF);
      i_reset = 1'b0;
      run(1);
      check("restart_dead_sel", 32'(o_sel), 32'h3F);
      run(1);
      check("restart_idx0_sel", 32'(o_sel), 32'h3E);
      run(30);

      // Adjust moves from seconds to hours while blink keeps running.
      i_adjust_cnt = 2'd1;
      run(33);
      i_adjust_cnt = 2'd3;
      run(48);

      // Random digits (including invalid codes) and adjust selections.
      for (int i = 0; i < 40; i++) begin
         set_time(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                  4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
         i_adjust_cnt = 2'($urandom_range(0, 3));
         run(int'($urandom_range(1, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
